simd_masked_alu: RTL

Lockstep SIMD integer ALU for the shader core: all `LANES` lanes execute the same opcode on per-lane operands, with a per-lane enable mask and a signed/unsigned mode. Single-cycle ops (add, sub, mul, min, max) finish in one execute cycle. Divide and remainder use a shared-control iterative restoring divider that runs in all lanes at once. It drop-in replaces the first-generation add/sub/mul/div lockstep ALU behind the same start/done handshake.

---
 rtl/simd_masked_alu.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/simd_masked_alu.sv
// Lockstep SIMD integer ALU: per-lane add/sub/mul/min/max in one cycle, plus a
// shared-control restoring divider for DIV/REM running in all lanes together.
module simd_masked_alu #(
  parameter int LANES     = 4,
  parameter int BIT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [2:0]                          op_code,
  input  logic                                is_signed,
  input  logic [LANES-1:0]                    lane_mask,
  input  logic [LANES-1:0][BIT_WIDTH-1:0]     a,
  input  logic [LANES-1:0][BIT_WIDTH-1:0]     b,
  output logic                                busy,
  output logic                                done,
  output logic [LANES-1:0][BIT_WIDTH-1:0]     result,
  output logic [LANES-1:0]                    div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIVIDE, S_FINISH} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM, OP_MIN, OP_MAX, OP_RSV
  } op_t;

  localparam int CW = $clog2(BIT_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(BIT_WIDTH - 1);

  state_t                          r_state, w_state_nxt;
  op_t                             r_op;
  logic                            r_signed, r_busy, r_done;
  logic [LANES-1:0]                r_mask, r_qneg, r_rneg, r_dz;
  logic [LANES-1:0][BIT_WIDTH-1:0] r_a, r_b, r_quo, r_rem, r_den, r_result;
  logic [CW-1:0]                   r_cnt;

  logic [LANES-1:0]                w_a_neg, w_b_neg, w_ge, w_lt, w_den_zero;
  logic [LANES-1:0][BIT_WIDTH-1:0] w_a_mag, w_b_mag, w_low, w_rem_nxt;
  logic [LANES-1:0][BIT_WIDTH-1:0] w_exec_res, w_fin_res;

  wire w_is_div_op = (op_code == OP_DIV) || (op_code == OP_REM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = w_is_div_op ? S_DIVIDE : S_EXEC;
      S_EXEC:   w_state_nxt = S_IDLE;
      S_DIVIDE: if (r_cnt == LAST_ITER) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_a_neg = '0; w_b_neg = '0; w_a_mag = '0; w_b_mag = '0;
    w_ge = '0; w_low = '0; w_rem_nxt = '0; w_lt = '0; w_den_zero = '0;
    w_exec_res = '0; w_fin_res = '0;
    for (int i = 0; i < LANES; i++) begin
      w_a_neg[i] = is_signed & a[i][BIT_WIDTH-1];
      w_b_neg[i] = is_signed & b[i][BIT_WIDTH-1];
      w_a_mag[i] = w_a_neg[i] ? -a[i] : a[i];
      w_b_mag[i] = w_b_neg[i] ? -b[i] : b[i];

      // Shifted partial remainder is BIT_WIDTH+1 bits; its top bit forces a subtract.
      w_low[i]     = {r_rem[i][BIT_WIDTH-2:0], r_quo[i][BIT_WIDTH-1]};
      w_ge[i]      = r_rem[i][BIT_WIDTH-1] | (w_low[i] >= r_den[i]);
      w_rem_nxt[i] = w_ge[i] ? (w_low[i] - r_den[i]) : w_low[i];

      w_lt[i] = r_signed ? ($signed(r_a[i]) < $signed(r_b[i])) : (r_a[i] < r_b[i]);
      case (r_op)
        OP_ADD:  w_exec_res[i] = r_a[i] + r_b[i];
        OP_SUB:  w_exec_res[i] = r_a[i] - r_b[i];
        OP_MUL:  w_exec_res[i] = r_a[i] * r_b[i];
        OP_MIN:  w_exec_res[i] = w_lt[i] ? r_a[i] : r_b[i];
        OP_MAX:  w_exec_res[i] = w_lt[i] ? r_b[i] : r_a[i];
        default: w_exec_res[i] = '0;
      endcase

      w_den_zero[i] = (r_den[i] == '0);
      if (r_op == OP_REM)
        w_fin_res[i] = w_den_zero[i] ? r_a[i] : (r_rneg[i] ? -r_rem[i] : r_rem[i]);
      else
        w_fin_res[i] = w_den_zero[i] ? '1 : (r_qneg[i] ? -r_quo[i] : r_quo[i]);
    end
  end

  // NOTE: operand/divider registers are reset too, so no X can leak into a masked lane.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op <= OP_ADD; r_signed <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
      r_mask <= '0; r_qneg <= '0; r_rneg <= '0; r_dz <= '0;
      r_a <= '0; r_b <= '0; r_quo <= '0; r_rem <= '0; r_den <= '0;
      r_result <= '0; r_cnt <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op     <= op_t'(op_code);
          r_signed <= is_signed;
          r_mask   <= lane_mask;
          r_a      <= a;
          r_b      <= b;
          r_quo    <= w_a_mag;
          r_den    <= w_b_mag;
          r_rem    <= '0;
          r_qneg   <= w_a_neg ^ w_b_neg;
          r_rneg   <= w_a_neg;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
        end
        S_EXEC: begin
          for (int i = 0; i < LANES; i++)
            if (r_mask[i]) r_result[i] <= w_exec_res[i];
          r_dz   <= '0;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        S_DIVIDE: begin
          for (int i = 0; i < LANES; i++)
            r_quo[i] <= {r_quo[i][BIT_WIDTH-2:0], w_ge[i]};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FINISH: begin
          for (int i = 0; i < LANES; i++)
            if (r_mask[i]) r_result[i] <= w_fin_res[i];
          r_dz   <= r_mask & w_den_zero;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dz;

endmodule
